// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl
//   Routes the HPS ioctl download byte stream into the game's ROM storage.
//   Each byte is decoded by address into one of these regions:
//     - main/sound CPU ROM -> SDRAM port1 (toggle handshake)
//     - sprite ROM         -> SDRAM port2 (toggle handshake, remapped so a
//                             sprite row lands in one 32-bit word pair)
//     - background ROM     -> on-chip BRAM (one-cycle write strobe)
//     - anything past the background ROM is dropped.
//   ioctl_wait stalls the HPS while an SDRAM handshake is outstanding.
//   The block also produces the sticky rom_loaded flag and the core reset.
//   The core reset is held during download, released one cycle after the
//   download ends, and pulsed once more for one cycle RESET_HOLD-1 cycles
//   later.
//
// Ports
//   clk_sys, reset_n             clock, async active-low reset
//   ioctl_download/wr/addr/dout  HPS byte stream (wr is a level, rising edge = byte)
//   ioctl_wait                   stall request back to HPS
//   port1_* / port2_*            SDRAM write ports (req toggles, done when ack==req)
//   dl_addr/dl_wr/dl_data        background ROM BRAM write
//   rom_loaded                   set after the first download completes, sticky
//   core_reset                   active-high reset to the game core
module rom_dl_ctrl #(
  parameter logic [24:0] SP_BASE    = 25'h12000,
  parameter logic [24:0] BG_BASE    = 25'h32000,
  parameter logic [24:0] BG_END     = 25'h3A000,
  parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [17:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [15:0] dl_addr,
  output logic        dl_wr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        core_reset
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {R_P1, R_P2, R_BG, R_DROP} region_e;

  state_e      state_q, state_d;
  logic        ioctl_wr_dly_q, ioctl_wr_dly_d;
  logic        ioctl_dl_dly_q, ioctl_dl_dly_d;
  logic [24:0] lat_addr_q, lat_addr_d;
  logic [7:0]  lat_data_q, lat_data_d;
  logic        lat_p2_q, lat_p2_d;        // selected port for the pending write
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        port1_req_q, port1_req_d;
  logic [22:0] port1_a_q, port1_a_d;
  logic [1:0]  port1_ds_q, port1_ds_d;
  logic [15:0] port1_d_q, port1_d_d;
  logic        port2_req_q, port2_req_d;
  logic [17:0] port2_a_q, port2_a_d;
  logic [1:0]  port2_ds_q, port2_ds_d;
  logic [15:0] port2_d_q, port2_d_d;
  logic [15:0] dl_addr_q, dl_addr_d;
  logic        dl_wr_q, dl_wr_d;
  logic [7:0]  dl_data_q, dl_data_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        core_reset_q, core_reset_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  logic        new_byte;
  region_e     region;
  logic [24:0] bg_off;
  logic [24:0] sp_off;
  logic        ack_done;
  logic        unused_bits;

  // Only the low offset bits reach the outputs; the rest is range-checked
  // by the region decode instead.
  assign bg_off      = ioctl_addr - BG_BASE;
  assign sp_off      = lat_addr_q - SP_BASE;
  assign unused_bits = &{1'b0, bg_off[24:16], sp_off[24:19]};

  assign new_byte = ioctl_download & ioctl_wr & ~ioctl_wr_dly_q;
  assign ack_done = lat_p2_q ? (port2_ack == port2_req_q)
                             : (port1_ack == port1_req_q);

  always_comb begin
    region = R_DROP;
    if (ioctl_addr < SP_BASE)      region = R_P1;
    else if (ioctl_addr < BG_BASE) region = R_P2;
    else if (ioctl_addr < BG_END)  region = R_BG;
  end

  always_comb begin
    state_d        = state_q;
    ioctl_wr_dly_d = ioctl_wr;
    ioctl_dl_dly_d = ioctl_download;
    lat_addr_d     = lat_addr_q;
    lat_data_d     = lat_data_q;
    lat_p2_d       = lat_p2_q;
    ioctl_wait_d   = ioctl_wait_q;
    port1_req_d    = port1_req_q;
    port1_a_d      = port1_a_q;
    port1_ds_d     = port1_ds_q;
    port1_d_d      = port1_d_q;
    port2_req_d    = port2_req_q;
    port2_a_d      = port2_a_q;
    port2_ds_d     = port2_ds_q;
    port2_d_d      = port2_d_q;
    dl_addr_d      = dl_addr_q;
    dl_wr_d        = 1'b0;
    dl_data_d      = dl_data_q;

    case (state_q)
      S_IDLE: begin
        if (new_byte) begin
          case (region)
            R_P1, R_P2: begin
              lat_addr_d   = ioctl_addr;
              lat_data_d   = ioctl_dout;
              lat_p2_d     = (region == R_P2);
              ioctl_wait_d = 1'b1;
              state_d      = S_ISSUE;
            end
            R_BG: begin
              // BRAM takes the byte immediately, so the HPS is never stalled.
              dl_addr_d = bg_off[15:0];
              dl_data_d = ioctl_dout;
              dl_wr_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_ISSUE: begin
        if (lat_p2_q) begin
          // Sprite remap: offset bit 16 becomes the word LSB and bit 15
          // the byte lane, so the ROM pairs interleave into 32-bit words.
          port2_a_d   = {sp_off[18:17], sp_off[14:0], sp_off[16]};
          port2_ds_d  = {sp_off[15], ~sp_off[15]};
          port2_d_d   = {lat_data_q, lat_data_q};
          port2_req_d = ~port2_req_q;
        end else begin
          port1_a_d   = lat_addr_q[23:1];
          port1_ds_d  = {lat_addr_q[0], ~lat_addr_q[0]};
          port1_d_d   = {lat_data_q, lat_data_q};
          port1_req_d = ~port1_req_q;
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Download state is ignored here: an issued toggle is always seen
        // through to its ack so req/ack stay paired.
        if (ack_done) begin
          ioctl_wait_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_loaded_d = rom_loaded_q | (ioctl_dl_dly_q & ~ioctl_download);
    if (~rom_loaded_q | ioctl_download)
      hold_cnt_d = RESET_HOLD;
    else if (hold_cnt_q != 16'd0)
      hold_cnt_d = hold_cnt_q - 16'd1;
    else
      hold_cnt_d = hold_cnt_q;
    // counter==1 gives the late one-cycle reset pulse after download end.
    core_reset_d = ~rom_loaded_q | ioctl_download | (hold_cnt_q == 16'd1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ioctl_wr_dly_q <= 1'b0;
      ioctl_dl_dly_q <= 1'b0;
      lat_addr_q     <= '0;
      lat_data_q     <= '0;
      lat_p2_q       <= 1'b0;
      ioctl_wait_q   <= 1'b0;
      port1_req_q    <= 1'b0;
      port1_a_q      <= '0;
      port1_ds_q     <= '0;
      port1_d_q      <= '0;
      port2_req_q    <= 1'b0;
      port2_a_q      <= '0;
      port2_ds_q     <= '0;
      port2_d_q      <= '0;
      dl_addr_q      <= '0;
      dl_wr_q        <= 1'b0;
      dl_data_q      <= '0;
      rom_loaded_q   <= 1'b0;
      core_reset_q   <= 1'b1;
      hold_cnt_q     <= RESET_HOLD;
    end else begin
      state_q        <= state_d;
      ioctl_wr_dly_q <= ioctl_wr_dly_d;
      ioctl_dl_dly_q <= ioctl_dl_dly_d;
      lat_addr_q     <= lat_addr_d;
      lat_data_q     <= lat_data_d;
      lat_p2_q       <= lat_p2_d;
      ioctl_wait_q   <= ioctl_wait_d;
      port1_req_q    <= port1_req_d;
      port1_a_q      <= port1_a_d;
      port1_ds_q     <= port1_ds_d;
      port1_d_q      <= port1_d_d;
      port2_req_q    <= port2_req_d;
      port2_a_q      <= port2_a_d;
      port2_ds_q     <= port2_ds_d;
      port2_d_q      <= port2_d_d;
      dl_addr_q      <= dl_addr_d;
      dl_wr_q        <= dl_wr_d;
      dl_data_q      <= dl_data_d;
      rom_loaded_q   <= rom_loaded_d;
      core_reset_q   <= core_reset_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign port1_req  = port1_req_q;
  assign port1_a    = port1_a_q;
  assign port1_ds   = port1_ds_q;
  assign port1_d    = port1_d_q;
  assign port2_req  = port2_req_q;
  assign port2_a    = port2_a_q;
  assign port2_ds   = port2_ds_q;
  assign port2_d    = port2_d_q;
  assign dl_addr    = dl_addr_q;
  assign dl_wr      = dl_wr_q;
  assign dl_data    = dl_data_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
module tb_rom_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        port1_req, port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack;
  logic [17:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic [15:0] dl_addr;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        rom_loaded, core_reset;

  always #5 clk_sys = ~clk_sys;

  rom_dl_ctrl #(.RESET_HOLD(16'h0010)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .dl_addr(dl_addr), .dl_wr(dl_wr), .dl_data(dl_data),
    .rom_loaded(rom_loaded), .core_reset(core_reset)
  );

  // kind: 0 = port1, 1 = port2, 2 = background, 3 = dropped
  // a: expected port1_a / port2_a / dl_addr depending on kind
  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  kind;
    logic [22:0] a;
    logic [1:0]  ds;
    string       name;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;

  // Expected port/BRAM output state, advanced only by the bench.
  logic        m_p1_req = 1'b0, m_p2_req = 1'b0;
  logic [22:0] m_p1_a = '0;
  logic [17:0] m_p2_a = '0;
  logic [1:0]  m_p1_ds = '0, m_p2_ds = '0;
  logic [15:0] m_p1_d = '0, m_p2_d = '0;
  logic [15:0] m_dl_addr = '0;
  logic [7:0]  m_dl_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    chk({tag, ":p1_req"},  32'(port1_req), 32'(m_p1_req));
    chk({tag, ":p1_a"},    32'(port1_a),   32'(m_p1_a));
    chk({tag, ":p1_ds"},   32'(port1_ds),  32'(m_p1_ds));
    chk({tag, ":p1_d"},    32'(port1_d),   32'(m_p1_d));
    chk({tag, ":p2_req"},  32'(port2_req), 32'(m_p2_req));
    chk({tag, ":p2_a"},    32'(port2_a),   32'(m_p2_a));
    chk({tag, ":p2_ds"},   32'(port2_ds),  32'(m_p2_ds));
    chk({tag, ":p2_d"},    32'(port2_d),   32'(m_p2_d));
    chk({tag, ":dl_addr"}, 32'(dl_addr),   32'(m_dl_addr));
    chk({tag, ":dl_data"}, 32'(dl_data),   32'(m_dl_data));
  endtask

  // Returns at the negedge one cycle after the strobe was sampled.
  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic model_write(input vec_t v);
    if (v.kind == 2'd0) begin
      m_p1_req = ~m_p1_req; m_p1_a = v.a; m_p1_ds = v.ds; m_p1_d = {v.data, v.data};
    end else if (v.kind == 2'd1) begin
      m_p2_req = ~m_p2_req; m_p2_a = v.a[17:0]; m_p2_ds = v.ds; m_p2_d = {v.data, v.data};
    end
  endtask

  task automatic run_vec(input vec_t v);
    strobe(v.addr, v.data);
    chk({v.name, ":wait_set"}, 32'(ioctl_wait), 32'(v.kind < 2'd2));
    chk({v.name, ":dl_wr"},    32'(dl_wr),      32'(v.kind == 2'd2));
    if (v.kind == 2'd2) begin
      m_dl_addr = v.a[15:0];
      m_dl_data = v.data;
    end
    @(negedge clk_sys);
    model_write(v);
    check_ports(v.name);
    chk({v.name, ":dl_wr_one"}, 32'(dl_wr), 32'(0));
    chk({v.name, ":wait_busy"}, 32'(ioctl_wait), 32'(v.kind < 2'd2));
    port1_ack = m_p1_req;
    port2_ack = m_p2_req;
    @(negedge clk_sys);
    chk({v.name, ":wait_clr"}, 32'(ioctl_wait), 32'(0));
    check_ports({v.name, "_post"});
  endtask

  initial begin
    vec_t v;
    int bad;

    vecs[0]  = '{25'h0000005, 8'h3C, 2'd0, 23'h000002, 2'b10, "p1_basic"};
    vecs[1]  = '{25'h0000000, 8'h11, 2'd0, 23'h000000, 2'b01, "p1_zero"};
    vecs[2]  = '{25'h0011FFF, 8'h7E, 2'd0, 23'h008FFF, 2'b10, "p1_top"};
    vecs[3]  = '{25'h001A001, 8'h5A, 2'd1, 23'h000002, 2'b10, "p2_8001"};
    vecs[4]  = '{25'h0012000, 8'hC3, 2'd1, 23'h000000, 2'b01, "p2_base"};
    vecs[5]  = '{25'h0031FFF, 8'h81, 2'd1, 23'h00FFFF, 2'b10, "p2_top"};
    vecs[6]  = '{25'h0022345, 8'h24, 2'd1, 23'h00068B, 2'b01, "p2_remap"};
    vecs[7]  = '{25'h0032010, 8'hA5, 2'd2, 23'h000010, 2'b00, "bg_basic"};
    vecs[8]  = '{25'h0032000, 8'h01, 2'd2, 23'h000000, 2'b00, "bg_base"};
    vecs[9]  = '{25'h0039FFF, 8'hFF, 2'd2, 23'h007FFF, 2'b00, "bg_top"};
    vecs[10] = '{25'h003A000, 8'h66, 2'd3, 23'h000000, 2'b00, "drop_end"};
    vecs[11] = '{25'h1FFFFFF, 8'h99, 2'd3, 23'h000000, 2'b00, "drop_max"};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; port1_ack = 1'b0; port2_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst:core_reset", 32'(core_reset), 32'(1));
    chk("rst:rom_loaded", 32'(rom_loaded), 32'(0));
    chk("rst:wait",       32'(ioctl_wait), 32'(0));
    chk("rst:dl_wr",      32'(dl_wr),      32'(0));
    check_ports("rst");

    reset_n = 1'b1;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("dl:core_reset", 32'(core_reset), 32'(1));
    chk("dl:rom_loaded", 32'(rom_loaded), 32'(0));

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Ack withheld for 50 cycles while extra strobes arrive.
    v = '{25'h0000100, 8'h42, 2'd0, 23'h000080, 2'b01, "held"};
    strobe(v.addr, v.data);
    chk("held:wait_set", 32'(ioctl_wait), 32'(1));
    @(negedge clk_sys);
    model_write(v);
    check_ports("held_issue");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (i == 10) begin ioctl_addr = 25'h0032020; ioctl_dout = 8'h77; ioctl_wr = 1'b1; end
      if (i == 12) ioctl_wr = 1'b0;
      if (i == 20) begin ioctl_addr = 25'h0000300; ioctl_dout = 8'hEE; ioctl_wr = 1'b1; end
      if (i == 22) ioctl_wr = 1'b0;
      if (!ioctl_wait || dl_wr) bad++;
    end
    chk("held:stall_cycles", 32'(bad), 32'(0));
    check_ports("held_hold");
    port1_ack = m_p1_req;
    @(negedge clk_sys);
    chk("held:wait_clr", 32'(ioctl_wait), 32'(0));
    @(negedge clk_sys);
    check_ports("held_after");
    run_vec('{25'h0000201, 8'h99, 2'd0, 23'h000100, 2'b10, "held_next"});

    // Download end: rom_loaded, reset release and late pulse.
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("end:rom_loaded", 32'(rom_loaded), 32'(1));
    @(negedge clk_sys);
    chk("end:core_reset_low", 32'(core_reset), 32'(0));
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk_sys);
      chk($sformatf("end:pulse_t%0d", k), 32'(core_reset), 32'(k == 17));
    end

    // Second download, aborted while a port2 handshake is outstanding.
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("dl2:core_reset", 32'(core_reset), 32'(1));
    chk("dl2:rom_loaded", 32'(rom_loaded), 32'(1));
    v = '{25'h0012004, 8'h3D, 2'd1, 23'h000008, 2'b01, "abort"};
    strobe(v.addr, v.data);
    chk("abort:wait_set", 32'(ioctl_wait), 32'(1));
    @(negedge clk_sys);
    model_write(v);
    check_ports("abort_issue");
    ioctl_download = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) bad++;
    end
    chk("abort:wait_held", 32'(bad), 32'(0));
    port2_ack = m_p2_req;
    @(negedge clk_sys);
    chk("abort:wait_clr", 32'(ioctl_wait), 32'(0));
    check_ports("abort_done");
    ioctl_download = 1'b1;
    run_vec('{25'h0032100, 8'h5E, 2'd2, 23'h000100, 2'b00, "abort_next"});

    // Async reset mid-operation.
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("rst2:core_reset", 32'(core_reset), 32'(1));
    chk("rst2:rom_loaded", 32'(rom_loaded), 32'(0));
    chk("rst2:p1_req",     32'(port1_req),  32'(0));
    chk("rst2:p2_req",     32'(port2_req),  32'(0));
    chk("rst2:p2_a",       32'(port2_a),    32'(0));
    chk("rst2:dl_addr",    32'(dl_addr),    32'(0));
    chk("rst2:wait",       32'(ioctl_wait), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
